// File: rtl/shift_word_feeder_pkg.sv
// shift_word_feeder shared types and defaults.
// Also consumed by the downstream shift stage.
package shift_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LEN_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } feeder_state_t;

endpackage

// File: rtl/shift_word_feeder_if.sv
// Upstream word handshake into the feeder.
// Master drives the word, slave returns ready.
interface shift_word_feeder_if #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int LEN_W = shift_pkg::LEN_W
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_len,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_len,
    output in_ready
  );

endinterface

// File: rtl/shift_word_feeder_fifo.sv
// Small synchronous FIFO holding {len, data}.
// Full/empty come from the stored level.
module shift_word_fifo #(
  parameter int DW    = 7,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_wdata,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // pointers wrap naturally; level tracks net push/pop
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/shift_word_feeder.sv
// Feeds buffered words to the shift stage with a
// per-word enable run and a one-cycle clearing gap.
module shift_word_feeder
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int DEPTH = shift_pkg::DEPTH,
  parameter int LEN_W = shift_pkg::LEN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  shift_word_feeder_if.slave         up,
  output logic [WIDTH-1:0]           out_din,
  output logic                       out_enable,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int DW = LEN_W + WIDTH;

  feeder_state_t    r_state;
  feeder_state_t    w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] w_din_nxt;
  logic             r_en;
  logic             w_en_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_rdata;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_len_eff;

  // ready is forced low while reset is held
  assign up.in_ready = !rst_n && !w_full;
  assign w_push      = up.in_valid && up.in_ready;
  assign w_len       = w_rdata[DW-1:WIDTH];
  assign w_len_eff   = (w_len == '0) ? LEN_W'(1) : w_len;

  assign out_din    = r_din;
  assign out_enable = r_en;
  assign done       = r_done;
  assign busy       = r_busy;

  shift_word_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({up.in_len, up.in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_din_nxt   = r_din;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE, GAP: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_din_nxt   = w_rdata[WIDTH-1:0];
          w_cnt_nxt   = w_len_eff;
          w_en_nxt    = 1'b1;
          w_done_nxt  = (w_len_eff == LEN_W'(1));
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == LEN_W'(1)) begin
          w_state_nxt = GAP;
        end else begin
          w_cnt_nxt  = r_cnt - LEN_W'(1);
          w_en_nxt   = 1'b1;
          w_done_nxt = (r_cnt == LEN_W'(2));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_din   <= w_din_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_shift_word_feeder.sv
// Directed bench for shift_word_feeder.
// Expected values are hand-derived per vector.
module tb_shift_word_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] out_din;
  logic       out_enable;
  logic       done;
  logic       busy;
  logic [2:0] fifo_level;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_word_feeder_if #(.WIDTH(4), .LEN_W(3)) bus ();

  shift_word_feeder #(
    .WIDTH (4),
    .DEPTH (4),
    .LEN_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (bus),
    .out_din    (out_din),
    .out_enable (out_enable),
    .done       (done),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [3:0] d,
                       input logic [2:0] l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_len   = l;
  endtask

  logic [3:0] wd [6];
  logic [2:0] wl [6];
  logic [3:0] got_q [$];
  logic [11:0] en_v;
  logic [11:0] dn_v;
  int peak;
  int idx;
  int acc6;
  int full_seen;
  int hits;
  logic acc;

  initial begin
    drive(1'b0, 4'h0, 3'h0);

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 4'($urandom), 3'($urandom));
      step();
    end
    chk("rst_din", out_din, 0);
    chk("rst_en", out_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy", bus.in_ready, 0);
    drive(1'b0, 4'h0, 3'h0);
    rst_n = 1'b0;
    #1;
    chk("rel_rdy", bus.in_ready, 1);
    chk("rel_lvl", fifo_level, 0);
    step();

    // single word, len 3
    drive(1'b1, 4'b1011, 3'd3);
    step();
    chk("s_lvl1", fifo_level, 1);
    chk("s_en0", out_enable, 0);
    drive(1'b0, 4'h0, 3'h0);
    step();
    chk("s_en_a", out_enable, 1);
    chk("s_din", out_din, 4'b1011);
    chk("s_dn_a", done, 0);
    chk("s_busy", busy, 1);
    chk("s_lvl0", fifo_level, 0);
    step();
    chk("s_en_b", out_enable, 1);
    chk("s_dn_b", done, 0);
    step();
    chk("s_en_c", out_enable, 1);
    chk("s_dn_c", done, 1);
    step();
    chk("s_gap_en", out_enable, 0);
    chk("s_gap_dn", done, 0);
    chk("s_gap_bsy", busy, 1);
    step();
    chk("s_idle_bsy", busy, 0);
    chk("s_idle_en", out_enable, 0);
    chk("s_hold_din", out_din, 4'b1011);

    // back-to-back, len 2
    wd[0] = 4'hA; wd[1] = 4'h5; wd[2] = 4'hC; wd[3] = 4'h3;
    en_v = '0;
    dn_v = '0;
    peak = 0;
    got_q.delete();
    for (int c = 0; c < 16; c++) begin
      if (c < 4) drive(1'b1, wd[c], 3'd2);
      else       drive(1'b0, 4'h0, 3'h0);
      step();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (c >= 1 && c <= 12) begin
        en_v = {en_v[10:0], out_enable};
        dn_v = {dn_v[10:0], done};
      end
      if (done) got_q.push_back(out_din);
    end
    chk("b_en_pat", en_v, 12'b110110110110);
    chk("b_dn_pat", dn_v, 12'b010010010010);
    chk("b_peak", peak, 3);
    chk("b_cnt", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("b_word", got_q[i], wd[i]);

    // full / backpressure
    for (int i = 0; i < 6; i++) begin
      wd[i] = 4'(i + 1);
      wl[i] = (i == 0) ? 3'd7 : 3'd1;
    end
    idx = 0;
    acc6 = -1;
    full_seen = 0;
    got_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (idx < 6) drive(1'b1, wd[idx], wl[idx]);
      else         drive(1'b0, 4'h0, 3'h0);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        if (idx == 5) acc6 = c;
        idx++;
      end
      if (fifo_level == 3'd4) begin
        full_seen = 1;
        chk("f_rdy_full", bus.in_ready, 0);
      end
      if (done) got_q.push_back(out_din);
    end
    chk("f_full_seen", full_seen, 1);
    chk("f_accepted", idx, 6);
    chk("f_held_acc", acc6, 10);
    chk("f_cnt", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) chk("f_word", got_q[i], wd[i]);

    // len 0 and push on pop cycles
    drive(1'b1, 4'h9, 3'd0);
    step();
    drive(1'b1, 4'h6, 3'd0);
    step();
    chk("z_en", out_enable, 1);
    chk("z_dn", done, 1);
    chk("z_din", out_din, 4'h9);
    chk("z_lvl_a", fifo_level, 1);
    drive(1'b0, 4'h0, 3'h0);
    step();
    chk("z_gap_en", out_enable, 0);
    chk("z_lvl_b", fifo_level, 1);
    drive(1'b1, 4'hE, 3'd0);
    step();
    chk("z_en2", out_enable, 1);
    chk("z_din2", out_din, 4'h6);
    chk("z_lvl_pp", fifo_level, 1);
    drive(1'b0, 4'h0, 3'h0);
    step();
    step();
    chk("z_din3", out_din, 4'hE);
    step();
    step();
    step();

    // reset mid-shift
    drive(1'b1, 4'h7, 3'd5);
    step();
    drive(1'b1, 4'h2, 3'd1);
    step();
    drive(1'b0, 4'h0, 3'h0);
    step();
    chk("r_en_pre", out_enable, 1);
    rst_n = 1'b1;
    #1;
    chk("r_en_now", out_enable, 0);
    chk("r_dn_now", done, 0);
    chk("r_lvl_now", fifo_level, 0);
    chk("r_bsy_now", busy, 0);
    chk("r_rdy_now", bus.in_ready, 0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("r_lvl_rel", fifo_level, 0);
    chk("r_rdy_rel", bus.in_ready, 1);
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_enable || done || busy) hits++;
    end
    chk("r_quiet", hits, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_word_feeder.md
# shift_word_feeder

Upstream feeder for the circular shift-register stage. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. For each word it presents the word on `out_din` and holds `out_enable` high for a per-word number of shift cycles, then drops `out_enable` for exactly one cycle. That low cycle clears the downstream register between words.

## Interface
- `WIDTH`, 4: data word width; must match the downstream shift stage (≥2).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `LEN_W`, 3: width of the per-word shift-length field.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_len`  in  LEN_W  shift cycles for this word; sampled with `in_data`.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `out_din`  out  WIDTH  word driven to the shift stage `din`.
- `out_enable`  out  1  drives the shift stage `enable`.
- `done`  out  1  one-cycle pulse on the last enable cycle of a word.
- `busy`  out  1  high when the FSM is not IDLE.
- `fifo_level`  out  $clog2(DEPTH+1)  entries currently stored.

## Operation
- Reset (`rst_n`=1) forces these values and holds them while asserted:
  - `out_din`=0, `out_enable`=0, `done`=0, `busy`=0, `fifo_level`=0, `in_ready`=0.
  - FIFO is emptied and the FSM goes to IDLE.
- After reset releases, `in_ready`=1 on the first cycle.
- Push: `in_valid && in_ready` at an edge stores {`in_len`, `in_data`}. When `in_ready`=0, data is held off and not dropped.
- `in_len`=0 is treated as 1.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if FIFO is non-empty, pop it, latch word into `out_din`, latch the length into the counter, go to SHIFT. Otherwise stay.
  - SHIFT: `out_enable`=1. Decrement the counter each cycle. On the cycle the counter equals 1, assert `done` and go to GAP.
  - GAP: `out_enable`=0 for exactly one cycle. If the FIFO is non-empty, pop and go to SHIFT. Otherwise go to IDLE.
- `out_din` holds the last popped word until the next pop; it is not cleared in GAP or IDLE.
- Push and pop in the same cycle:
  - Legal whenever `in_ready`=1; level is unchanged.
  - When full, `in_ready`=0, so there is no same-cycle bypass.
- Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are derived from `fifo_level`.
- All outputs are registered except `in_ready`, which is decoded from the registered level.

## Timing
- Word accepted at edge k into an empty FIFO with FSM IDLE:
  - `fifo_level`=1 after k.
  - Pop at k+1; `out_enable`=1 from k+1 through k+1+N (N cycles).
  - `done`=1 in cycle k+N.
  - `out_enable`=0 after edge k+1+N (GAP).
- Back-to-back words: exactly one `out_enable`-low cycle between consecutive words; no extra IDLE cycle.
- Throughput: one word per N+1 cycles.
- Reset asserted mid-SHIFT: `out_enable` drops immediately (asynchronous) and all queued words are lost.

## Structure
- Shared package `shift_pkg`: state enum `feeder_state_t` {IDLE, SHIFT, GAP} and the default `WIDTH`, `DEPTH`, `LEN_W` constants. These are shared with the shift stage.
- One sub-module, `shift_word_fifo`: synchronous FIFO with push/pop, level, full and empty outputs, storing {len, data}.
- The FSM, counter and output registers live in the top module.

## Test plan
- Reset check: hold `rst_n`=1 with random inputs → all outputs 0 and `in_ready`=0. Release → `in_ready`=1 and `fifo_level`=0.
- Single word: push `in_data`=4'b1011, `in_len`=3 → `out_din`=1011; `out_enable` high for 3 cycles; `done` on the 3rd; then 1 low cycle; then IDLE with `busy`=0.
- Back-to-back: push 4 words with `in_len`=2 each → enable pattern 1,1,0 repeated 4 times, 4 `done` pulses, `fifo_level` peaks at 3 or 4.
- Full/backpressure: stall output by pushing 6 words while the first shifts with `in_len`=7:
  - `in_ready`=0 when `fifo_level`=4.
  - Held word is accepted after the next pop.
  - No word is lost or duplicated.
- Length zero plus simultaneous push/pop: `in_len`=0 → exactly 1 enable cycle. Push on the GAP pop cycle at level 1 → level stays 1.
- Reset mid-SHIFT: assert `rst_n` on the 2nd of 5 enable cycles → `out_enable`=0 at once, no `done`, FIFO empty after release.
